uart_tx_top: RTL and testbench

Transmit half of the UART: a programmable baud/oversample tick generator (`uart_bdgen`) feeding a frame serializer (`uart_tx`). It accepts one parallel byte per frame and drives the serial line with start, data (LSB first), optional parity and 1–2 stop bits. It sits between the host register interface and the `uart_txd` pad; `pls_rx` is also exported for the receive path.

---
 rtl/uart_config_pkg.sv | 38 +++
 rtl/uart_bdgen.sv | 51 +++++
 rtl/uart_tx.sv | 135 +++++++++++++
 rtl/uart_tx_top.sv | 41 ++++
 tb/tb_uart_tx_top.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/uart_config_pkg.sv
// Shared configuration types for the UART transmit path: run-time option
// structs, the transmitter state encoding and config clamping helpers.
package uart_config;

  typedef struct packed {
    logic [15:0] divisor;
    logic [4:0]  osm_rate;
  } uart_config_bdgen;

  typedef struct packed {
    logic       parity_en;
    logic       parity_even;
    logic [3:0] data_len;
    logic [1:0] stop_len;
  } uart_config_tx;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  function automatic logic [3:0] clamp_data_len(input logic [3:0] len);
    if (len < 4'd5) return 4'd5;
    if (len > 4'd8) return 4'd8;
    return len;
  endfunction

  function automatic logic [1:0] clamp_stop_len(input logic [1:0] len);
    if (len == 2'd0) return 2'd1;
    if (len == 2'd3) return 2'd2;
    return len;
  endfunction

endpackage

// File: rtl/uart_bdgen.sv
// Baud generator: divides clk into oversample ticks (pls_rx) and groups
// osm_rate of those into one bit tick (pls_tx).
module uart_bdgen
  import uart_config::*;
(
  input  logic             clk,
  input  logic             rst,
  input  uart_config_bdgen cfg,
  output logic             pls_rx,
  output logic             pls_tx
);

  logic [15:0] div_q, div_d, div_last;
  logic [4:0]  osm_q, osm_d, osm_last;
  logic        div_wrap, osm_wrap;
  logic        pls_rx_q, pls_rx_d;
  logic        pls_tx_q, pls_tx_d;

  // Wrap on >= so a config shrunk below the current count recovers at once.
  always_comb begin
    div_last = (cfg.divisor == 16'd0) ? 16'd0 : cfg.divisor - 16'd1;
    osm_last = (cfg.osm_rate == 5'd0) ? 5'd0 : cfg.osm_rate - 5'd1;
    div_wrap = (div_q >= div_last);
    osm_wrap = (osm_q >= osm_last);
    div_d    = div_wrap ? 16'd0 : div_q + 16'd1;
    osm_d    = osm_q;
    if (div_wrap) begin
      osm_d = osm_wrap ? 5'd0 : osm_q + 5'd1;
    end
    pls_rx_d = div_wrap;
    pls_tx_d = div_wrap && osm_wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= 16'd0;
      osm_q    <= 5'd0;
      pls_rx_q <= 1'b0;
      pls_tx_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      osm_q    <= osm_d;
      pls_rx_q <= pls_rx_d;
      pls_tx_q <= pls_tx_d;
    end
  end

  assign pls_rx = pls_rx_q;
  assign pls_tx = pls_tx_q;

endmodule

// File: rtl/uart_tx.sv
// Frame serializer: loads one byte into the TSR and shifts out start, data
// (LSB first), optional parity and stop bits, one bit per pls_tx interval.
module uart_tx
  import uart_config::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          pls_tx,
  input  uart_config_tx cfg,
  input  logic          vld_tx,
  input  logic [7:0]    data,
  output logic          uart_txd,
  output logic          busy_tx,
  output logic          empty_tsr,
  output logic          done_tx
);

  tx_state_e     state_q, state_d;
  logic [7:0]    tsr_q, tsr_d;
  uart_config_tx cfg_q, cfg_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [1:0]    stop_cnt_q, stop_cnt_d;
  logic          par_q, par_d;
  logic          txd_q, txd_d;
  logic          done_q, done_d;

  // txd is registered on the transition, so each bit starts the clk after pls_tx.
  always_comb begin
    state_d    = state_q;
    tsr_d      = tsr_q;
    cfg_d      = cfg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    txd_d      = txd_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (vld_tx) begin
          state_d           = ST_WAIT;
          tsr_d             = data;
          cfg_d.parity_en   = cfg.parity_en;
          cfg_d.parity_even = cfg.parity_even;
          cfg_d.data_len    = clamp_data_len(cfg.data_len);
          cfg_d.stop_len    = clamp_stop_len(cfg.stop_len);
        end
      end
      ST_WAIT: begin
        if (pls_tx) begin
          state_d = ST_START;
          txd_d   = 1'b0;
        end
      end
      ST_START: begin
        if (pls_tx) begin
          state_d   = ST_DATA;
          txd_d     = tsr_q[0];
          tsr_d     = {1'b0, tsr_q[7:1]};
          par_d     = tsr_q[0];
          bit_cnt_d = 4'd1;
        end
      end
      ST_DATA: begin
        if (pls_tx) begin
          if (bit_cnt_q == cfg_q.data_len) begin
            if (cfg_q.parity_en) begin
              state_d = ST_PARITY;
              txd_d   = cfg_q.parity_even ? par_q : ~par_q;
            end else begin
              state_d    = ST_STOP;
              txd_d      = 1'b1;
              stop_cnt_d = 2'd1;
            end
          end else begin
            txd_d     = tsr_q[0];
            tsr_d     = {1'b0, tsr_q[7:1]};
            par_d     = par_q ^ tsr_q[0];
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (pls_tx) begin
          state_d    = ST_STOP;
          txd_d      = 1'b1;
          stop_cnt_d = 2'd1;
        end
      end
      ST_STOP: begin
        if (pls_tx) begin
          if (stop_cnt_q == cfg_q.stop_len) begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tsr_q      <= 8'd0;
      cfg_q      <= '0;
      bit_cnt_q  <= 4'd0;
      stop_cnt_q <= 2'd0;
      par_q      <= 1'b0;
      txd_q      <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tsr_q      <= tsr_d;
      cfg_q      <= cfg_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      txd_q      <= txd_d;
      done_q     <= done_d;
    end
  end

  assign uart_txd  = txd_q;
  assign busy_tx   = (state_q != ST_IDLE);
  assign empty_tsr = (state_q == ST_IDLE);
  assign done_tx   = done_q;

endmodule

// File: rtl/uart_tx_top.sv
// UART transmit half: baud/oversample tick generator feeding the frame
// serializer; the oversample tick is exported for the receive path.
module uart_tx_top
  import uart_config::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  uart_config_bdgen ucfg_bdgen,
  input  uart_config_tx    ucfg_trx,
  input  logic             vld_tx,
  input  logic [7:0]       data,
  output logic             uart_txd,
  output logic             busy_tx,
  output logic             empty_tsr,
  output logic             done_tx,
  output logic             pls_rx,
  output logic             pls_tx
);

  uart_bdgen u_bdgen (
    .clk    (clk),
    .rst    (rstn),
    .cfg    (ucfg_bdgen),
    .pls_rx (pls_rx),
    .pls_tx (pls_tx)
  );

  uart_tx u_tx (
    .clk       (clk),
    .rst       (rstn),
    .pls_tx    (pls_tx),
    .cfg       (ucfg_trx),
    .vld_tx    (vld_tx),
    .data      (data),
    .uart_txd  (uart_txd),
    .busy_tx   (busy_tx),
    .empty_tsr (empty_tsr),
    .done_tx   (done_tx)
  );

endmodule

// File: tb/tb_uart_tx_top.sv
// Directed self-checking bench for uart_tx_top: frame bit patterns, parity,
// data length, tick spacing, back-to-back frames and mid-frame reset.
module tb_uart_tx_top;
  import uart_config::*;

  logic             clk;
  logic             rstn;
  uart_config_bdgen ucfg_bdgen;
  uart_config_tx    ucfg_trx;
  logic             vld_tx;
  logic [7:0]       data;
  logic             uart_txd;
  logic             busy_tx;
  logic             empty_tsr;
  logic             done_tx;
  logic             pls_rx;
  logic             pls_tx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  uart_tx_top dut (
    .clk        (clk),
    .rstn       (rstn),
    .ucfg_bdgen (ucfg_bdgen),
    .ucfg_trx   (ucfg_trx),
    .vld_tx     (vld_tx),
    .data       (data),
    .uart_txd   (uart_txd),
    .busy_tx    (busy_tx),
    .empty_tsr  (empty_tsr),
    .done_tx    (done_tx),
    .pls_rx     (pls_rx),
    .pls_tx     (pls_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic pen, input logic peven,
                               input logic [3:0] dlen, input logic [1:0] slen);
    data                 = d;
    ucfg_trx.parity_en   = pen;
    ucfg_trx.parity_even = peven;
    ucfg_trx.data_len    = dlen;
    ucfg_trx.stop_len    = slen;
  endtask

  // Raise vld_tx until the byte is accepted, then drop it.
  task automatic loadByte(input string tag);
    int n;
    n = 0;
    vld_tx = 1'b1;
    @(negedge clk);
    while (busy_tx !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, " load"}, busy_tx, 1'b1);
    vld_tx = 1'b0;
  endtask

  // Find the start edge, check every clk of every bit, then the done pulse.
  task automatic checkFrame(input string tag, input logic [15:0] exp_bits, input int nbits,
                            input int period, input int max_wait, output int waited);
    waited = 0;
    while (uart_txd !== 1'b0 && waited < max_wait) begin
      @(negedge clk);
      waited++;
    end
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < period; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        checkOutput($sformatf("%s bit%0d clk%0d", tag, b, c), uart_txd, exp_bits[b]);
        if (b == nbits - 1 && c == period - 1)
          checkOutput({tag, " done_early"}, done_tx, 1'b0);
      end
    end
    @(negedge clk);
    checkOutput({tag, " done"}, done_tx, 1'b1);
    checkOutput({tag, " busy_end"}, busy_tx, 1'b0);
    checkOutput({tag, " idle_line"}, uart_txd, 1'b1);
  endtask

  initial begin
    int waited;
    int rel;
    int n;

    rstn                = 1'b1;
    vld_tx              = 1'b0;
    ucfg_bdgen.divisor  = 16'd2;
    ucfg_bdgen.osm_rate = 5'd2;
    applyStimulus(8'h0F, 1'b1, 1'b1, 4'd8, 2'd2);
    vld_tx = 1'b1;
    repeat (3) @(negedge clk);

    checkOutput("rst txd", uart_txd, 1'b1);
    checkOutput("rst busy", busy_tx, 1'b0);
    checkOutput("rst empty", empty_tsr, 1'b1);
    checkOutput("rst done", done_tx, 1'b0);
    checkOutput("rst pls_rx", pls_rx, 1'b0);
    checkOutput("rst pls_tx", pls_tx, 1'b0);

    // Frame 1: 0x0F, 8 bits, even parity, 2 stop; vld_tx held high.
    rstn = 1'b0;
    rel  = cyc;
    checkFrame("f1", 16'h0C1E, 12, 4, 20, waited);
    checkOutput("f1 within60", 16'((cyc - rel) <= 60), 16'd1);
    checkOutput("b2b empty_pulse", empty_tsr, 1'b1);
    @(negedge clk);
    checkOutput("b2b empty_low", empty_tsr, 1'b0);
    checkOutput("b2b busy", busy_tx, 1'b1);
    vld_tx = 1'b0;
    checkFrame("f2", 16'h0C1E, 12, 4, 20, waited);
    checkOutput("b2b gap", 16'(waited <= 4), 16'd1);

    // Odd parity; config changed after load must not affect the frame.
    @(negedge clk);
    applyStimulus(8'h0F, 1'b1, 1'b0, 4'd8, 2'd2);
    loadByte("odd");
    applyStimulus(8'h00, 1'b0, 1'b1, 4'd5, 2'd1);
    checkFrame("odd", 16'h0E1E, 12, 4, 20, waited);

    @(negedge clk);
    applyStimulus(8'h01, 1'b1, 1'b1, 4'd8, 2'd2);
    loadByte("even01");
    checkFrame("even01", 16'h0E02, 12, 4, 20, waited);

    @(negedge clk);
    applyStimulus(8'hFF, 1'b0, 1'b1, 4'd5, 2'd1);
    loadByte("len5");
    checkFrame("len5", 16'h007E, 7, 4, 20, waited);

    // Tick spacing with div=3, osm=4.
    ucfg_bdgen.divisor  = 16'd3;
    ucfg_bdgen.osm_rate = 5'd4;
    n = 0;
    @(negedge clk);
    while (pls_tx !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tick sync", pls_tx, 1'b1);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      checkOutput($sformatf("tick rx%0d", k), pls_rx, 16'((k % 3) == 0));
      checkOutput($sformatf("tick tx%0d", k), pls_tx, 16'((k % 12) == 0));
    end
    ucfg_bdgen.divisor  = 16'd2;
    ucfg_bdgen.osm_rate = 5'd2;

    // Reset during DATA (data bit 1 of 0xA5 is 0 on the line).
    @(negedge clk);
    applyStimulus(8'hA5, 1'b1, 1'b1, 4'd8, 2'd2);
    loadByte("mrst");
    n = 0;
    while (uart_txd !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    checkOutput("mrst pre txd", uart_txd, 1'b0);
    checkOutput("mrst pre busy", busy_tx, 1'b1);
    rstn = 1'b1;
    #1;
    checkOutput("mrst txd", uart_txd, 1'b1);
    checkOutput("mrst busy", busy_tx, 1'b0);
    checkOutput("mrst empty", empty_tsr, 1'b1);
    checkOutput("mrst done", done_tx, 1'b0);
    checkOutput("mrst pls_tx", pls_tx, 1'b0);
    @(negedge clk);
    applyStimulus(8'h0F, 1'b1, 1'b1, 4'd8, 2'd2);
    vld_tx = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    checkFrame("post", 16'h0C1E, 12, 4, 20, waited);
    vld_tx = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
